// File: rtl/input_device.sv
`default_nettype none
// ============================================================================
// Module   : input_device
// Purpose  : Front-panel button conditioner: synchronises and edge-detects the
//            five panel buttons, selects a field and edits its BCD value, and
//            issues reset/write commands to the timekeeping core.
//            Optional build macro: INPUT_DEVICE_AUTOREPEAT_EN (val inc/dec
//            auto-repeat while held).
// Revision : 1.0 - initial release
// ============================================================================
module input_device (
  input  logic       i_clk,
  input  logic       i_reset_btn,
  input  logic       i_ena,
  input  logic       i_wr_btn,
  input  logic       i_val_inc_btn,
  input  logic       i_val_dec_btn,
  input  logic       i_sel_inc_btn,
  input  logic       i_sel_dec_btn,
  input  logic [7:0] i_in,
  output logic       o_reset,
  output logic       o_wr,
  output logic [1:0] o_sel,
  output logic [7:0] o_val
);

  localparam int c_WR   = 0;
  localparam int c_VINC = 1;
  localparam int c_VDEC = 2;
  localparam int c_SINC = 3;
  localparam int c_SDEC = 4;

  localparam logic [7:0] c_LIM_HR  = 8'h23;
  localparam logic [7:0] c_LIM_MS  = 8'h59;
  localparam logic [1:0] c_SEL_HR  = 2'd2;

  logic [4:0] w_btn_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_prev;
  logic [4:0] w_press;
  logic       r_dirty;

  logic       w_vinc_evt;
  logic       w_vdec_evt;
  logic       w_sel_fwd;
  logic       w_sel_back;
  logic       w_val_up;
  logic       w_val_dn;

  logic [7:0] w_limit;
  logic       w_legal;
  logic [7:0] w_val_inc;
  logic [7:0] w_val_dec;
  logic [1:0] w_sel_next;
  logic [1:0] w_sel_prev;

  assign w_btn_raw = {i_sel_dec_btn, i_sel_inc_btn, i_val_dec_btn,
                      i_val_inc_btn, i_wr_btn};

  always_ff @(posedge i_clk) begin
    if (i_reset_btn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      if (i_ena) begin
        r_prev <= r_sync2;
      end
    end
  end

  // A press is a rising level seen between two consecutive sampling ticks.
  assign w_press = i_ena ? (r_sync2 & ~r_prev) : 5'b0;

`ifdef INPUT_DEVICE_AUTOREPEAT_EN
  localparam logic [4:0] c_RPT_LAST   = 5'd19;
  localparam logic [4:0] c_RPT_RELOAD = 5'd16;

  logic [1:0] w_rpt;

  // r_hold counts consecutive held samples; first repeat on sample 20, then every 4.
  for (genvar g = 0; g < 2; g++) begin : g_rpt
    logic [4:0] r_hold;

    always_ff @(posedge i_clk) begin
      if (i_reset_btn) begin
        r_hold <= '0;
      end else if (i_ena) begin
        if (!r_sync2[c_VINC + g]) begin
          r_hold <= '0;
        end else if (r_hold == c_RPT_LAST) begin
          r_hold <= c_RPT_RELOAD;
        end else begin
          r_hold <= r_hold + 5'd1;
        end
      end
    end

    assign w_rpt[g] = i_ena && r_sync2[c_VINC + g] && (r_hold == c_RPT_LAST);
  end

  assign w_vinc_evt = w_press[c_VINC] | w_rpt[0];
  assign w_vdec_evt = w_press[c_VDEC] | w_rpt[1];
`else
  assign w_vinc_evt = w_press[c_VINC];
  assign w_vdec_evt = w_press[c_VDEC];
`endif

  assign w_sel_fwd  = w_press[c_SINC] & ~w_press[c_SDEC];
  assign w_sel_back = w_press[c_SDEC] & ~w_press[c_SINC];
  assign w_val_up   = w_vinc_evt & ~w_vdec_evt;
  assign w_val_dn   = w_vdec_evt & ~w_vinc_evt;

  assign w_sel_next = (o_sel == c_SEL_HR) ? 2'd0 : o_sel + 2'd1;
  assign w_sel_prev = (o_sel == 2'd0) ? c_SEL_HR : o_sel - 2'd1;

  // BCD step with field limit; illegal codes snap to 0x00 (inc) or limit (dec).
  always_comb begin
    w_limit   = (o_sel == c_SEL_HR) ? c_LIM_HR : c_LIM_MS;
    w_legal   = (o_val[3:0] <= 4'd9) && (o_val[7:4] <= 4'd9) && (o_val <= w_limit);
    w_val_inc = 8'h00;
    w_val_dec = w_limit;
    if (w_legal) begin
      if (o_val == w_limit) begin
        w_val_inc = 8'h00;
      end else if (o_val[3:0] == 4'd9) begin
        w_val_inc = {o_val[7:4] + 4'd1, 4'd0};
      end else begin
        w_val_inc = o_val + 8'd1;
      end

      if (o_val == 8'h00) begin
        w_val_dec = w_limit;
      end else if (o_val[3:0] == 4'd0) begin
        w_val_dec = {o_val[7:4] - 4'd1, 4'd9};
      end else begin
        w_val_dec = o_val - 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_btn) begin
      o_reset <= 1'b1;
      o_wr    <= 1'b0;
      o_sel   <= 2'd0;
      o_val   <= 8'h00;
      r_dirty <= 1'b0;
    end else begin
      o_reset <= 1'b0;
      o_wr    <= 1'b0;
      if (w_press[c_WR]) begin
        o_wr    <= 1'b1;
        r_dirty <= 1'b0;
      end else if (w_sel_fwd) begin
        o_sel   <= w_sel_next;
        r_dirty <= 1'b0;
      end else if (w_sel_back) begin
        o_sel   <= w_sel_prev;
        r_dirty <= 1'b0;
      end else if (w_val_up) begin
        o_val   <= w_val_inc;
        r_dirty <= 1'b1;
      end else if (w_val_dn) begin
        o_val   <= w_val_dec;
        r_dirty <= 1'b1;
      end else if (i_ena && !r_dirty) begin
        o_val   <= i_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_device
// Purpose  : Self-checking bench for input_device with a small core model that
//            supplies the live field value and absorbs writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_device;

  logic       i_clk;
  logic       i_reset_btn;
  logic       i_ena;
  logic       i_wr_btn;
  logic       i_val_inc_btn;
  logic       i_val_dec_btn;
  logic       i_sel_inc_btn;
  logic       i_sel_dec_btn;
  logic [7:0] i_in;
  logic       o_reset;
  logic       o_wr;
  logic [1:0] o_sel;
  logic [7:0] o_val;

  logic [7:0] core_val [0:3];
  int         ena_cnt;
  int         n_checks;
  int         n_errors;

  // btn bits: {sel_dec, sel_inc, val_dec, val_inc, wr}
  typedef struct {
    logic [4:0] btn;
    logic       set_core;
    logic [7:0] core_v;
    logic [1:0] exp_sel;
    logic [7:0] exp_val;
  } vec_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] val;
  } obs_t;

  vec_t vecs[$];
  obs_t sb[$];
  obs_t wr_exp[$];
  obs_t wr_seen[$];

  input_device dut (
    .i_clk         (i_clk),
    .i_reset_btn   (i_reset_btn),
    .i_ena         (i_ena),
    .i_wr_btn      (i_wr_btn),
    .i_val_inc_btn (i_val_inc_btn),
    .i_val_dec_btn (i_val_dec_btn),
    .i_sel_inc_btn (i_sel_inc_btn),
    .i_sel_dec_btn (i_sel_dec_btn),
    .i_in          (i_in),
    .o_reset       (o_reset),
    .o_wr          (o_wr),
    .o_sel         (o_sel),
    .o_val         (o_val)
  );

  assign i_in = core_val[o_sel];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    ena_cnt = 0;
    i_ena   = 1'b0;
    forever begin
      @(negedge i_clk);
      ena_cnt = (ena_cnt == 4) ? 0 : ena_cnt + 1;
      i_ena   = (ena_cnt == 0);
    end
  end

  always @(negedge i_clk) begin
    if (o_wr === 1'b1) begin
      wr_seen.push_back({o_sel, o_val});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {i_sel_dec_btn, i_sel_inc_btn, i_val_dec_btn, i_val_inc_btn, i_wr_btn} = m;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic press(input logic [4:0] m);
    set_btns(m);
    wait_cyc(12);
    set_btns(5'b0);
    wait_cyc(12);
  endtask

  function automatic void add(input logic [4:0] b, input logic sc, input logic [7:0] cv,
                              input logic [1:0] s, input logic [7:0] v);
    vec_t t;
    t.btn = b; t.set_core = sc; t.core_v = cv; t.exp_sel = s; t.exp_val = v;
    vecs.push_back(t);
  endfunction

  initial begin
    obs_t e;
    obs_t w;
    logic [7:0] hold_exp;

    n_checks = 0;
    n_errors = 0;
    core_val[0] = 8'h37;
    core_val[1] = 8'h15;
    core_val[2] = 8'h23;
    core_val[3] = 8'h00;
    i_reset_btn = 1'b1;
    set_btns(5'b0);

    add(5'b00010, 0, 8'h00, 2'd0, 8'h38);
    add(5'b00010, 0, 8'h00, 2'd0, 8'h39);
    add(5'b00010, 0, 8'h00, 2'd0, 8'h40);
    add(5'b00010, 0, 8'h00, 2'd0, 8'h41);
    add(5'b00010, 0, 8'h00, 2'd0, 8'h42);
    add(5'b00001, 0, 8'h00, 2'd0, 8'h42);
    add(5'b00010, 0, 8'h00, 2'd0, 8'h43);
    add(5'b01000, 0, 8'h00, 2'd1, 8'h15);
    add(5'b01000, 0, 8'h00, 2'd2, 8'h23);
    add(5'b00010, 0, 8'h00, 2'd2, 8'h00);
    add(5'b01000, 0, 8'h00, 2'd0, 8'h42);
    add(5'b10000, 0, 8'h00, 2'd2, 8'h23);
    add(5'b10000, 0, 8'h00, 2'd1, 8'h15);
    add(5'b10000, 0, 8'h00, 2'd0, 8'h42);
    add(5'b00110, 0, 8'h00, 2'd0, 8'h42);
    add(5'b11000, 0, 8'h00, 2'd0, 8'h42);
    add(5'b00000, 1, 8'h00, 2'd0, 8'h00);
    add(5'b00100, 0, 8'h00, 2'd0, 8'h59);
    add(5'b00100, 0, 8'h00, 2'd0, 8'h58);
    add(5'b00011, 0, 8'h00, 2'd0, 8'h58);
    add(5'b00000, 1, 8'h7A, 2'd0, 8'h7A);
    add(5'b00010, 0, 8'h00, 2'd0, 8'h00);
    add(5'b10000, 0, 8'h00, 2'd2, 8'h23);
    add(5'b01000, 0, 8'h00, 2'd0, 8'h7A);
    add(5'b00100, 0, 8'h00, 2'd0, 8'h59);
    add(5'b01000, 0, 8'h00, 2'd1, 8'h15);
    add(5'b00100, 0, 8'h00, 2'd1, 8'h14);
    add(5'b00001, 0, 8'h00, 2'd1, 8'h14);
    add(5'b10000, 0, 8'h00, 2'd0, 8'h7A);
    add(5'b10000, 0, 8'h00, 2'd2, 8'h23);
    add(5'b00000, 1, 8'h24, 2'd2, 8'h24);
    add(5'b00010, 0, 8'h00, 2'd2, 8'h00);
    add(5'b01000, 0, 8'h00, 2'd0, 8'h7A);

    // Reset held for 100 ns
    wait_cyc(10);
    check("reset o_reset", {31'b0, o_reset}, 32'h1);
    check("reset o_sel", {30'b0, o_sel}, 32'h0);
    check("reset o_val", {24'b0, o_val}, 32'h00);
    check("reset o_wr", {31'b0, o_wr}, 32'h0);
    i_reset_btn = 1'b0;
    wait_cyc(1);
    check("release o_reset", {31'b0, o_reset}, 32'h0);
    wait_cyc(12);
    check("release live o_val", {24'b0, o_val}, 32'h37);

    foreach (vecs[k]) begin
      if (vecs[k].set_core) core_val[vecs[k].exp_sel] = vecs[k].core_v;
      sb.push_back({vecs[k].exp_sel, vecs[k].exp_val});
      if (vecs[k].btn[0]) wr_exp.push_back({vecs[k].exp_sel, vecs[k].exp_val});
      set_btns(vecs[k].btn);
      wait_cyc(12);
      set_btns(5'b0);
      if (vecs[k].btn[0]) core_val[vecs[k].exp_sel] = vecs[k].exp_val;
      wait_cyc(12);
      e = sb.pop_front();
      check($sformatf("vec%0d o_sel", k), {30'b0, o_sel}, {30'b0, e.sel});
      check($sformatf("vec%0d o_val", k), {24'b0, o_val}, {24'b0, e.val});
    end

    // Reset in the middle of an edit on the minutes field
    press(5'b01000);
    press(5'b00010);
    check("pre-reset edit o_val", {24'b0, o_val}, 32'h15);
    i_reset_btn = 1'b1;
    wait_cyc(3);
    check("mid-edit reset o_reset", {31'b0, o_reset}, 32'h1);
    check("mid-edit reset o_sel", {30'b0, o_sel}, 32'h0);
    check("mid-edit reset o_val", {24'b0, o_val}, 32'h00);
    i_reset_btn = 1'b0;
    wait_cyc(12);
    check("post-reset live o_val", {24'b0, o_val}, 32'h7A);

    // Long hold of val_inc: 26 sampling ticks with the level high
    core_val[0] = 8'h10;
    wait_cyc(12);
    check("hold start o_val", {24'b0, o_val}, 32'h10);
`ifdef INPUT_DEVICE_AUTOREPEAT_EN
    hold_exp = 8'h13;
`else
    hold_exp = 8'h11;
`endif
    set_btns(5'b00010);
    wait_cyc(130);
    set_btns(5'b0);
    wait_cyc(12);
    check("long hold o_val", {24'b0, o_val}, {24'b0, hold_exp});

    check("write count", wr_seen.size(), wr_exp.size());
    while (wr_seen.size() > 0 && wr_exp.size() > 0) begin
      w = wr_seen.pop_front();
      e = wr_exp.pop_front();
      check("write sel", {30'b0, w.sel}, {30'b0, e.sel});
      check("write val", {24'b0, w.val}, {24'b0, e.val});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
